// File: rtl/apb_gpio_pkg.sv
`default_nettype none
// ============================================================================
// apb_gpio_pkg : FSM states, default widths and GPIO register offsets
//                (ST_WAIT exists only when APB_WAIT_EN is defined)
// Revision     : 1.0
// ============================================================================
package apb_gpio_pkg;

  localparam int c_def_addr_width = 8;
  localparam int c_def_data_width = 32;

  localparam logic [7:0] c_off_dir  = 8'h00;
  localparam logic [7:0] c_off_in   = 8'h04;
  localparam logic [7:0] c_off_out  = 8'h08;
  localparam logic [7:0] c_off_set  = 8'h0C;
  localparam logic [7:0] c_off_clr  = 8'h10;
  localparam logic [7:0] c_off_mode = 8'h14;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
`ifdef APB_WAIT_EN
    , ST_WAIT = 2'd3
`endif
  } state_t;

endpackage
`default_nettype wire

// File: rtl/apb_gpio_bridge.sv
`default_nettype none
// ============================================================================
// apb_gpio_bridge : APB slave to GPIO register-port bridge, fixed latency.
//                   Define APB_WAIT_EN to add one wait cycle before PREADY.
// Revision        : 1.0
// ============================================================================
module apb_gpio_bridge
  import apb_gpio_pkg::*;
#(
  parameter int ADDR_WIDTH = c_def_addr_width,
  parameter int DATA_WIDTH = c_def_data_width
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic                    PREADY,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PSLVERR,
  output logic                    gpio_wr_en,
  output logic                    gpio_rd_en,
  output logic [ADDR_WIDTH-1:0]   gpio_reg_addr,
  output logic [DATA_WIDTH-1:0]   gpio_wdata,
  output logic [DATA_WIDTH/8-1:0] gpio_strb,
  input  logic [DATA_WIDTH-1:0]   gpio_rdata,
  input  logic                    gpio_error
);

  localparam int c_strb_width = DATA_WIDTH / 8;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_setup;
  logic                    w_enable;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_write;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [c_strb_width-1:0] r_strb;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_err;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_setup     = 1'b0;
    w_enable    = 1'b0;
    gpio_wr_en  = 1'b0;
    gpio_rd_en  = 1'b0;
    PREADY      = 1'b0;
    PRDATA      = '0;
    PSLVERR     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          w_setup     = 1'b1;
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // A dropped PSEL/PENABLE here is an abort: no GPIO strobe, no response
        if (PSEL && PENABLE) begin
          w_enable   = 1'b1;
          gpio_wr_en = r_write;
          gpio_rd_en = !r_write;
`ifdef APB_WAIT_EN
          w_state_nxt = ST_WAIT;
`else
          w_state_nxt = ST_RESP;
`endif
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
`ifdef APB_WAIT_EN
      ST_WAIT: w_state_nxt = ST_RESP;
`endif
      ST_RESP: begin
        PREADY      = 1'b1;
        PRDATA      = r_rdata;
        PSLVERR     = r_err;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_setup) begin
        r_addr  <= PADDR;
        r_write <= PWRITE;
        r_wdata <= PWDATA;
        r_strb  <= PWRITE ? PSTRB : '0;
      end
      if (w_enable) begin
        r_rdata <= r_write ? '0 : gpio_rdata;
        r_err   <= gpio_error;
      end
    end
  end

  assign gpio_reg_addr = r_addr;
  assign gpio_wdata    = r_wdata;
  assign gpio_strb     = r_strb;

endmodule
`default_nettype wire

// File: tb/tb_apb_gpio_bridge.sv
`default_nettype none
// tb_apb_gpio_bridge : randomized APB transfers checked every cycle against a
//                      transfer-level expectation model, plus literal pins.
module tb_apb_gpio_bridge;
  import apb_gpio_pkg::*;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY, PSLVERR;
  logic [31:0] PRDATA;
  logic        gpio_wr_en, gpio_rd_en;
  logic [7:0]  gpio_reg_addr;
  logic [31:0] gpio_wdata;
  logic [3:0]  gpio_strb;
  logic [31:0] gpio_rdata;
  logic        gpio_error;

  apb_gpio_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA),
    .PSLVERR(PSLVERR), .gpio_wr_en(gpio_wr_en), .gpio_rd_en(gpio_rd_en),
    .gpio_reg_addr(gpio_reg_addr), .gpio_wdata(gpio_wdata), .gpio_strb(gpio_strb),
    .gpio_rdata(gpio_rdata), .gpio_error(gpio_error)
  );

  always #5 PCLK = ~PCLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected outputs for the current cycle, maintained by the transfer tasks
  logic        exp_wr, exp_rd, exp_ready, exp_err;
  logic [31:0] exp_rdata;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_strb;

  // Values observed at notable cycles of the last transfer
  logic        cap_wr, cap_rd, cap_ready, cap_err;
  logic [7:0]  cap_addr;
  logic [31:0] cap_wdata, cap_rdata;
  logic [3:0]  cap_strb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge PCLK) begin
    check("gpio_wr_en",    64'(gpio_wr_en),    64'(exp_wr));
    check("gpio_rd_en",    64'(gpio_rd_en),    64'(exp_rd));
    check("PREADY",        64'(PREADY),        64'(exp_ready));
    check("PRDATA",        64'(PRDATA),        64'(exp_rdata));
    check("PSLVERR",       64'(PSLVERR),       64'(exp_err));
    check("gpio_reg_addr", 64'(gpio_reg_addr), 64'(m_addr));
    check("gpio_wdata",    64'(gpio_wdata),    64'(m_wdata));
    check("gpio_strb",     64'(gpio_strb),     64'(m_strb));
  end

  task automatic quiet();
    exp_wr = 1'b0; exp_rd = 1'b0; exp_ready = 1'b0; exp_err = 1'b0; exp_rdata = 32'h0;
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Non-setup bus activity: must never start a transfer
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      PSEL    = 1'b0;
      PENABLE = 1'($urandom);
      if ($urandom_range(0, 4) == 0) begin PSEL = 1'b1; PENABLE = 1'b1; end
      PWRITE = 1'($urandom); PADDR = 8'($urandom); PWDATA = $urandom; PSTRB = 4'($urandom);
      gpio_rdata = $urandom; gpio_error = 1'($urandom);
      quiet();
      tick();
    end
  endtask

  // abort: 0 = complete, 1 = PSEL dropped at T1, 2 = PENABLE low at T1
  task automatic xfer(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input logic [31:0] rd, input logic err, input int abort);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd; PSTRB = st;
    gpio_rdata = $urandom; gpio_error = 1'($urandom);
    quiet();
    tick();
    m_addr = a; m_wdata = wd; m_strb = wr ? st : 4'h0;
    gpio_rdata = rd; gpio_error = err;
    if (abort != 0) begin
      PSEL = (abort == 2); PENABLE = 1'b0;
      @(negedge PCLK);
      cap_wr = gpio_wr_en; cap_rd = gpio_rd_en;
      tick();
      return;
    end
    PENABLE = 1'b1;
    exp_wr = wr; exp_rd = !wr;
    @(negedge PCLK);
    cap_wr = gpio_wr_en; cap_rd = gpio_rd_en; cap_addr = gpio_reg_addr;
    cap_wdata = gpio_wdata; cap_strb = gpio_strb;
    tick();
    gpio_rdata = $urandom; gpio_error = 1'($urandom);
    quiet();
`ifdef APB_WAIT_EN
    tick();
`endif
    exp_ready = 1'b1; exp_rdata = wr ? 32'h0 : rd; exp_err = err;
    @(negedge PCLK);
    cap_ready = PREADY; cap_rdata = PRDATA; cap_err = PSLVERR;
    tick();
    quiet();
  endtask

  task automatic reset_mid(input logic wr, input logic [7:0] a, input logic [31:0] wd);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd; PSTRB = 4'hF;
    quiet();
    tick();
    m_addr = a; m_wdata = wd; m_strb = wr ? 4'hF : 4'h0;
    PENABLE = 1'b1; exp_wr = wr; exp_rd = !wr;
    #2;
    PRESETn = 1'b0;
    quiet(); m_addr = 8'h0; m_wdata = 32'h0; m_strb = 4'h0;
    #1;
    check("rst_imm_enables", 64'(gpio_wr_en | gpio_rd_en), 0);
    check("rst_imm_pready",  64'(PREADY), 0);
    tick();
    PSEL = 1'b0; PENABLE = 1'b0;
    tick();
    PRESETn = 1'b1;
    idle(3);
  endtask

  initial begin
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h0;
    PWDATA = 32'h0; PSTRB = 4'h0; gpio_rdata = 32'h0; gpio_error = 1'b0;
    quiet(); m_addr = 8'h0; m_wdata = 32'h0; m_strb = 4'h0;
    tick(); tick();
    PRESETn = 1'b1;
    idle(2);

    xfer(1'b1, c_off_dir, 32'h0000_00FF, 4'hF, 32'h0, 1'b0, 0);
    check("w_t1_wr_en", 64'(cap_wr), 1);
    check("w_t1_rd_en", 64'(cap_rd), 0);
    check("w_t1_addr",  64'(cap_addr), 64'h00);
    check("w_t1_wdata", 64'(cap_wdata), 64'hFF);
    check("w_t1_strb",  64'(cap_strb), 64'hF);
    check("w_t2_ready", 64'(cap_ready), 1);
    check("w_t2_err",   64'(cap_err), 0);
    idle(1);

    xfer(1'b0, c_off_out, 32'h1234_5678, 4'hF, 32'hA5A5_A5A5, 1'b0, 0);
    check("r_t1_rd_en",  64'(cap_rd), 1);
    check("r_t1_strb",   64'(cap_strb), 0);
    check("r_t2_prdata", 64'(cap_rdata), 64'hA5A5_A5A5);
    check("r_t2_ready",  64'(cap_ready), 1);
    @(negedge PCLK);
    check("r_t3_prdata", 64'(PRDATA), 0);
    tick();

    xfer(1'b1, 8'h3C, 32'hCAFE_0001, 4'h3, 32'h0, 1'b1, 0);
    check("e_t1_wr_en", 64'(cap_wr), 1);
    check("e_t2_err",   64'(cap_err), 1);
    check("e_t2_ready", 64'(cap_ready), 1);

    xfer(1'b0, c_off_in, 32'h0, 4'h0, 32'h0, 1'b0, 1);
    check("abort_en", 64'(cap_wr | cap_rd), 0);
    xfer(1'b0, c_off_mode, 32'h0, 4'h5, 32'h0F0F_1234, 1'b0, 0);
    check("post_abort_rdata", 64'(cap_rdata), 64'h0F0F_1234);

    reset_mid(1'b1, c_off_set, 32'h5555_AAAA);
    xfer(1'b0, c_off_clr, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 0);
    check("post_rst_ready", 64'(cap_ready), 1);
    check("post_rst_rdata", 64'(cap_rdata), 64'hDEAD_BEEF);

    for (int k = 0; k < 200; k++) begin
      int ab;
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
      if ($urandom_range(0, 29) == 0) begin
        reset_mid(1'($urandom), 8'($urandom), $urandom);
      end else begin
        xfer(1'($urandom), 8'($urandom), $urandom, 4'($urandom), $urandom,
             ($urandom_range(0, 3) == 0), ab);
      end
      idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_gpio_bridge.md
APB_GPIO_BRIDGE -- requirements
Module: apb_gpio_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning APB and GPIO register address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, a multiple of 8, meaning data width; strobe width is DATA_WIDTH/8.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: PCLK  input  1  clock; PRESETn  input  1  async active-low reset.
REQ-004 SHALL have the APB inputs: PSEL 1, PENABLE 1, PWRITE 1, PADDR ADDR_WIDTH, PWDATA DATA_WIDTH, PSTRB DATA_WIDTH/8.
REQ-005 SHALL have the APB outputs: PREADY 1, PRDATA DATA_WIDTH, PSLVERR 1.
REQ-006 SHALL have the GPIO-side outputs: gpio_wr_en 1, gpio_rd_en 1, gpio_reg_addr ADDR_WIDTH, gpio_wdata DATA_WIDTH, gpio_strb DATA_WIDTH/8.
REQ-007 SHALL have the GPIO-side inputs: gpio_rdata DATA_WIDTH and gpio_error 1, both combinational responses sampled during the enable cycle.

Function
REQ-008 SHALL implement an FSM with states IDLE, ACCESS, RESP, and WAIT when APB_WAIT_EN is defined.
REQ-009 IDLE: on PSEL=1 and PENABLE=0, SHALL latch PADDR, PWRITE, PWDATA and PSTRB, then go to ACCESS; all other input combinations stay in IDLE.
REQ-010 ACCESS with PSEL=1 and PENABLE=1: SHALL assert exactly one of gpio_wr_en or gpio_rd_en for exactly one cycle, driving the latched address, data and strobe.
REQ-011 ACCESS: SHALL register gpio_rdata (reads only, otherwise 0) and gpio_error, then go to RESP (or WAIT).
REQ-012 ACCESS with PSEL=0 or PENABLE=0 (protocol abort): SHALL assert no enable and SHALL return to IDLE without a response.
REQ-013 RESP: SHALL drive PREADY=1, PRDATA=registered data and PSLVERR=registered error for one cycle, then go to IDLE.
REQ-014 PREADY, PSLVERR and PRDATA SHALL be 0 in every state other than RESP.
REQ-015 Latency SHALL be fixed: setup at T0, enable at T1, PREADY at T2; the minimum transfer is 3 PCLK cycles.
REQ-016 For reads, gpio_strb SHALL be driven as all-zero regardless of PSTRB.
REQ-017 gpio_wdata, gpio_reg_addr and gpio_strb SHALL hold their latched values outside the enable cycle; the enables are the only qualifiers.
REQ-018 A new setup arriving in the cycle after RESP SHALL be accepted, giving back-to-back transfers every 3 (or 4) cycles.
REQ-019 PSLVERR SHALL reflect gpio_error for both reads and writes; write data is still presented to the GPIO on error.

Reset
REQ-020 PRESETn low SHALL immediately force state IDLE, gpio_wr_en=0, gpio_rd_en=0, PREADY=0, PSLVERR=0 and PRDATA=0, and clear all latches to 0.
REQ-021 Reset asserted mid-transfer SHALL abandon the transfer with no enable pulse after release; the first post-reset setup is serviced normally.

Configuration
REQ-022 Macro APB_WAIT_EN: when defined, SHALL insert state WAIT for one cycle between ACCESS and RESP, with PREADY=0 and registered data held, giving latency T3.
REQ-023 Without APB_WAIT_EN, ACCESS SHALL go directly to RESP and the WAIT state SHALL not exist.

Structure
REQ-024 Package apb_gpio_pkg SHALL hold the FSM state enum, the default widths, and the register offsets DIR=0x00, IN=0x04, OUT=0x08, SET=0x0C, CLR=0x10, MODE=0x14.
REQ-025 SHALL be a single module with no sub-module; the GPIO register block instantiates separately and connects port-to-port.

Verification
REQ-026 Write PADDR=0x00, PWDATA=0x0000_00FF, PSTRB=0xF -> gpio_wr_en high only at T1 with addr 0x00, data 0xFF, strb 0xF; PREADY=1 and PSLVERR=0 at T2.
REQ-027 Read PADDR=0x08 with the GPIO returning 0xA5A5_A5A5 at T1 -> gpio_rd_en high at T1 with strb 0x0; PRDATA=0xA5A5_A5A5 and PREADY=1 at T2, PRDATA=0 at T3.
REQ-028 Write PADDR=0x3C with gpio_error=1 at T1 -> PSLVERR=1 with PREADY at T2; PSLVERR=0 in all other cycles.
REQ-029 Setup at T0, then PSEL=0 at T1 -> no enable pulse, no PREADY, state back in IDLE; a following legal read completes normally.
REQ-030 PRESETn pulsed low during ACCESS -> enables and PREADY go low immediately and no pulse follows; with APB_WAIT_EN defined, a read completes with PREADY at T3 and data intact.
